// File: rtl/pack_pkg.sv
// Shared types for the pack sequencer: FSM state encoding and the stage select
// that steers the registered byte mux.
package pack_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_DATA = 3'd2,
    S_TAIL = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HEAD = 2'd1,
    SEL_BODY = 2'd2,
    SEL_TAIL = 2'd3
  } sel_e;

  function automatic sel_e state_to_sel(input state_e s);
    case (s)
      S_HEAD:  return SEL_HEAD;
      S_DATA:  return SEL_BODY;
      S_TAIL:  return SEL_TAIL;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pack_mux.sv
// Registered 3:1 byte mux plus packet byte counter. Only the selected stage's
// bytes are forwarded; pack_data is held at 0 whenever nothing is forwarded.
module pack_mux
  import pack_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clr,
  input  sel_e             sel,
  input  logic [7:0]       head_data,
  input  logic             head_vld,
  input  logic [7:0]       body_data,
  input  logic             body_vld,
  input  logic [7:0]       tail_data,
  input  logic             tail_vld,
  output logic [7:0]       pack_data,
  output logic             pack_vld,
  output logic [LEN_W-1:0] byte_cnt_nxt
);

  logic [7:0]       pack_data_q, pack_data_d;
  logic             pack_vld_q, pack_vld_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    pack_vld_d  = 1'b0;
    pack_data_d = 8'h00;
    case (sel)
      SEL_HEAD: begin pack_vld_d = head_vld; pack_data_d = head_vld ? head_data : 8'h00; end
      SEL_BODY: begin pack_vld_d = body_vld; pack_data_d = body_vld ? body_data : 8'h00; end
      SEL_TAIL: begin pack_vld_d = tail_vld; pack_data_d = tail_vld ? tail_data : 8'h00; end
      default:  ;
    endcase
    // Counter wraps naturally at 2^LEN_W.
    byte_cnt_d = clr ? '0 : byte_cnt_q + {{(LEN_W-1){1'b0}}, pack_vld_d};
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pack_data_q <= 8'h00;
      pack_vld_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      pack_data_q <= pack_data_d;
      pack_vld_q  <= pack_vld_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign pack_data    = pack_data_q;
  assign pack_vld     = pack_vld_q;
  assign byte_cnt_nxt = byte_cnt_d;

endmodule

// File: rtl/pack_ctrl.sv
// Packet sequencer: runs head, data, tail stages per fire_pack and merges their
// bytes. Optional stage watchdog enabled by defining PACK_CTRL_TIMEOUT_EN.
module pack_ctrl
  import pack_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16,
  parameter int TO_CYC = 1024
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             fire_pack,
  output logic             done_pack,
  output logic             busy,
  output logic             fire_head,
  input  logic             done_head,
  input  logic [7:0]       head_data,
  input  logic             head_vld,
  output logic             fire_data,
  input  logic             done_data,
  input  logic [7:0]       body_data,
  input  logic             body_vld,
  output logic             fire_tail,
  input  logic             done_tail,
  input  logic [7:0]       tail_data,
  input  logic             tail_vld,
  output logic [7:0]       pack_data,
  output logic             pack_vld,
  output logic [LEN_W-1:0] pack_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err_pack
);

  // Handshake: fire_x is a one-cycle pulse in the first cycle of a stage; the
  // stage answers with a one-cycle done_x, accepted from the fire cycle onward.
  // done_x/vld from a stage that is not currently active are ignored.
  state_e           state_q, state_d;
  logic             fire_head_q, fire_head_d;
  logic             fire_data_q, fire_data_d;
  logic             fire_tail_q, fire_tail_d;
  logic             done_pack_q, done_pack_d;
  logic             err_pack_q, err_pack_d;
  logic [LEN_W-1:0] pack_len_q, pack_len_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             clr;
  logic [LEN_W-1:0] byte_cnt_nxt;

`ifdef PACK_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            stage_done;
  logic            in_stage;
`endif

  always_comb begin
    state_d     = state_q;
    fire_head_d = 1'b0;
    fire_data_d = 1'b0;
    fire_tail_d = 1'b0;
    done_pack_d = 1'b0;
    err_pack_d  = 1'b0;
    pack_len_d  = pack_len_q;
    pkt_cnt_d   = pkt_cnt_q;
    clr         = 1'b0;
    case (state_q)
      S_IDLE: if (fire_pack) begin
        state_d     = S_HEAD;
        fire_head_d = 1'b1;
        clr         = 1'b1;
      end
      S_HEAD: if (done_head) begin
        state_d     = S_DATA;
        fire_data_d = 1'b1;
      end
      S_DATA: if (done_data) begin
        state_d     = S_TAIL;
        fire_tail_d = 1'b1;
      end
      S_TAIL: if (done_tail) begin
        // Length includes the tail byte being registered on this same edge.
        state_d     = S_DONE;
        done_pack_d = 1'b1;
        pack_len_d  = byte_cnt_nxt;
        pkt_cnt_d   = pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PACK_CTRL_TIMEOUT_EN
    in_stage   = (state_q == S_HEAD) || (state_q == S_DATA) || (state_q == S_TAIL);
    stage_done = ((state_q == S_HEAD) && done_head) || ((state_q == S_DATA) && done_data) ||
                 ((state_q == S_TAIL) && done_tail);
    // wdog_q counts completed cycles in the stage; a done on the limit cycle wins.
    if (in_stage && !stage_done && (wdog_q == WD_W'(TO_CYC - 1))) begin
      state_d    = S_ERR;
      err_pack_d = 1'b1;
    end
    wdog_d = (in_stage && (state_d == state_q)) ? wdog_q + {{(WD_W-1){1'b0}}, 1'b1} : '0;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fire_head_q <= 1'b0;
      fire_data_q <= 1'b0;
      fire_tail_q <= 1'b0;
      done_pack_q <= 1'b0;
      err_pack_q  <= 1'b0;
      pack_len_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fire_head_q <= fire_head_d;
      fire_data_q <= fire_data_d;
      fire_tail_q <= fire_tail_d;
      done_pack_q <= done_pack_d;
      err_pack_q  <= err_pack_d;
      pack_len_q  <= pack_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

`ifdef PACK_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
  assign err_pack = err_pack_q;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC != 0) | err_pack_q;
  assign err_pack      = 1'b0;
`endif

  pack_mux #(.LEN_W(LEN_W)) u_mux (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .clr          (clr),
    .sel          (state_to_sel(state_q)),
    .head_data    (head_data),
    .head_vld     (head_vld),
    .body_data    (body_data),
    .body_vld     (body_vld),
    .tail_data    (tail_data),
    .tail_vld     (tail_vld),
    .pack_data    (pack_data),
    .pack_vld     (pack_vld),
    .byte_cnt_nxt (byte_cnt_nxt)
  );

  assign busy      = (state_q != S_IDLE);
  assign fire_head = fire_head_q;
  assign fire_data = fire_data_q;
  assign fire_tail = fire_tail_q;
  assign done_pack = done_pack_q;
  assign pack_len  = pack_len_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pack_ctrl.sv
// Bench for pack_ctrl: stage responders, byte-stream scoreboard and packet
// length/count reference model. Small LEN_W/CNT_W make both counters wrap.
module tb_pack_ctrl;

  localparam int LEN_W  = 5;
  localparam int CNT_W  = 4;
  localparam int TO_CYC = 16;

  logic             clk_sys = 1'b0;
  logic             rst = 1'b1;
  logic             fire_pack = 1'b0;
  logic             done_head = 1'b0, done_data = 1'b0, done_tail = 1'b0;
  logic [7:0]       head_data = 8'h00, body_data = 8'h00, tail_data = 8'h00;
  logic             head_vld = 1'b0, body_vld = 1'b0, tail_vld = 1'b0;
  logic             done_pack, busy, fire_head, fire_data, fire_tail, pack_vld, err_pack;
  logic [7:0]       pack_data;
  logic [LEN_W-1:0] pack_len;
  logic [CNT_W-1:0] pkt_cnt;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int model_len = 0;
  int model_cnt = 0;
  int last_len  = 0;

  pack_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
    .clk_sys(clk_sys), .rst(rst), .fire_pack(fire_pack), .done_pack(done_pack), .busy(busy),
    .fire_head(fire_head), .done_head(done_head), .head_data(head_data), .head_vld(head_vld),
    .fire_data(fire_data), .done_data(done_data), .body_data(body_data), .body_vld(body_vld),
    .fire_tail(fire_tail), .done_tail(done_tail), .tail_data(tail_data), .tail_vld(tail_vld),
    .pack_data(pack_data), .pack_vld(pack_vld), .pack_len(pack_len), .pkt_cnt(pkt_cnt),
    .err_pack(err_pack)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard: every forwarded byte must be the oldest byte a stage offered while active.
  always @(negedge clk_sys) begin
    vectors++;
    if (pack_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL stream_extra: got byte %h, none expected", pack_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (pack_data !== exp_b) begin
          errors++; $display("FAIL stream_byte: got %h want %h", pack_data, exp_b);
        end
      end
    end else if ({pack_vld, pack_data} !== 9'h000) begin
      errors++; $display("FAIL stream_idle: got vld %b data %h want 0/00", pack_vld, pack_data);
    end
`ifndef PACK_CTRL_TIMEOUT_EN
    vectors++;
    if (err_pack !== 1'b0) begin
      errors++; $display("FAIL err_pack_tied: got %b want 0", err_pack);
    end
`endif
  end

  task automatic step;
    @(negedge clk_sys);
    #1;
  endtask

  task automatic clear_inputs;
    fire_pack = 1'b0;
    done_head = 1'b0; done_data = 1'b0; done_tail = 1'b0;
    head_vld  = 1'b0; body_vld  = 1'b0; tail_vld  = 1'b0;
    head_data = 8'h00; body_data = 8'h00; tail_data = 8'h00;
  endtask

  task automatic set_stage(input int st, input logic vld, input logic [7:0] d, input logic dn);
    case (st)
      0:       begin head_vld = vld; head_data = d; done_head = dn; end
      1:       begin body_vld = vld; body_data = d; done_data = dn; end
      default: begin tail_vld = vld; tail_data = d; done_tail = dn; end
    endcase
  endtask

  // Acts as one stage: nb bytes on consecutive cycles from the fire cycle, done
  // on cycle max(dly, nb-1). stray adds inputs that must be ignored.
  task automatic drive_stage(input int st, input int nb, input int dly, input bit stray);
    int last;
    logic [7:0] b;
    logic fire_got;
    last = (nb - 1 > dly) ? nb - 1 : dly;
    for (int c = 0; c <= last; c++) begin
      fire_got = (st == 0) ? fire_head : (st == 1) ? fire_data : fire_tail;
      vectors++;
      if (fire_got !== 1'(c == 0)) begin
        errors++; $display("FAIL fire_stage%0d: cycle %0d got %b want %b", st, c, fire_got, c == 0);
      end
      vectors++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy_stage%0d: cycle %0d got %b want 1", st, c, busy);
      end
      b = 8'($urandom_range(0, 255));
      if (c < nb) begin
        exp_q.push_back(b);
        model_len++;
      end
      set_stage(st, c < nb, b, c == last);
      if (stray && st == 0 && c == 0) done_tail = 1'b1;
      if (stray && st == 1) begin
        tail_vld  = 1'b1;
        tail_data = ~b;
        fire_pack = (c == 0);
      end
      step;
      clear_inputs;
    end
  endtask

  task automatic run_packet(input int hn, input int bn, input int tn,
                            input int hd, input int bd, input int td, input bit stray);
    model_len = 0;
    fire_pack = 1'b1;
    step;
    fire_pack = 1'b0;
    drive_stage(0, hn, hd, stray);
    drive_stage(1, bn, bd, stray);
    drive_stage(2, tn, td, stray);
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    last_len  = model_len % (1 << LEN_W);
    vectors++;
    if (done_pack !== 1'b1) begin
      errors++; $display("FAIL done_pack_pulse: got %b want 1", done_pack);
    end
    vectors++;
    if (pack_len !== LEN_W'(last_len)) begin
      errors++; $display("FAIL pack_len: got %0d want %0d", pack_len, last_len);
    end
    vectors++;
    if (pkt_cnt !== CNT_W'(model_cnt)) begin
      errors++; $display("FAIL pkt_cnt: got %0d want %0d", pkt_cnt, model_cnt);
    end
    fire_pack = stray;
    step;
    fire_pack = 1'b0;
    vectors++;
    if ({done_pack, busy, fire_head} !== 3'b000) begin
      errors++; $display("FAIL after_done: got done/busy/fire_head %b%b%b want 000", done_pack, busy, fire_head);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({pack_vld, pack_data, busy, fire_head, fire_data, fire_tail, done_pack, err_pack,
         pack_len, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: got vld=%b data=%h busy=%b fires=%b%b%b done=%b err=%b len=%0d cnt=%0d want all 0",
               name, pack_vld, pack_data, busy, fire_head, fire_data, fire_tail, done_pack, err_pack,
               pack_len, pkt_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    step;
    check_all_zero("idle_outputs");
  endtask

  task automatic test_nominal;
    run_packet(4, 10, 2, 3, 3, 3, 1'b0);
  endtask

  task automatic test_immediate;
    run_packet(0, 0, 0, 0, 0, 0, 1'b0);
    run_packet(1, 1, 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_ignored;
    run_packet(3, 5, 2, 2, 4, 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    model_len = 0;
    fire_pack = 1'b1;
    step;
    fire_pack = 1'b0;
    drive_stage(0, 2, 2, 1'b0);
    for (int c = 0; c < 2; c++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      set_stage(1, 1'b1, b, 1'b0);
      step;
      clear_inputs;
    end
    rst = 1'b1;
    step;
    check_all_zero("reset_mid_outputs");
    rst = 1'b0;
    model_cnt = 0;
    last_len  = 0;
    step;
    check_all_zero("reset_mid_idle");
    run_packet(2, 3, 1, 1, 2, 0, 1'b0);
  endtask

`ifdef PACK_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    model_len = 0;
    fire_pack = 1'b1;
    step;
    fire_pack = 1'b0;
    drive_stage(0, 2, 1, 1'b0);
    for (int c = 0; c < TO_CYC; c++) begin
      if (c == 0) begin
        vectors++;
        if (fire_data !== 1'b1) begin
          errors++; $display("FAIL to_fire_data: got %b want 1", fire_data);
        end
      end
      step;
    end
    vectors++;
    if ({err_pack, busy, done_pack} !== 3'b110) begin
      errors++; $display("FAIL to_err_pulse: got err/busy/done %b%b%b want 110", err_pack, busy, done_pack);
    end
    step;
    vectors++;
    if ({err_pack, busy, done_pack} !== 3'b000) begin
      errors++; $display("FAIL to_after_err: got err/busy/done %b%b%b want 000", err_pack, busy, done_pack);
    end
    vectors++;
    if ({pack_len, pkt_cnt} !== {LEN_W'(last_len), CNT_W'(model_cnt)}) begin
      errors++; $display("FAIL to_counters: got len %0d cnt %0d want %0d %0d", pack_len, pkt_cnt, last_len, model_cnt);
    end
    run_packet(1, 2, 1, 0, TO_CYC - 1, 0, 1'b0);
  endtask
`else
  task automatic test_timeout;
    run_packet(1, 2, 1, 0, TO_CYC + 4, 0, 1'b0);
  endtask
`endif

  task automatic test_wrap;
    for (int p = 0; p < 20; p++) begin
      run_packet($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_immediate;
    test_ignored;
    test_reset_mid;
    test_timeout;
    test_wrap;
    step;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stream_missing: %0d bytes never forwarded, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
